// File: rtl/motor_pkg.sv
// Shared types and widths for the stepper motion-profile blocks.
package motor_pkg;

  localparam int unsigned POS_W    = 32;
  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned LEVEL_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StRun,
    StHold
  } ramp_state_t;

  // Clamp a 17-bit intermediate period to the 16-bit range.
  function automatic logic [PERIOD_W-1:0] sat_period(input logic [PERIOD_W:0] v);
    return v[PERIOD_W] ? '1 : v[PERIOD_W-1:0];
  endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable step-interval down-counter plus fixed-width pulse generator.
// A load of N makes the pulse rise N clocks later; after a rise the counter
// idles until the next load, so the owner decides every interval.
module step_timer
  import motor_pkg::*;
#(
  parameter int unsigned PULSE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [PERIOD_W:0] i_load_val,
  input  logic              i_cancel,
  output logic              o_step_edge,
  output logic              o_rotate_pulse,
  output logic              o_pulse_fall
);

  localparam int unsigned WidthW = $clog2(PULSE_W + 1);
  localparam logic [PERIOD_W:0] CntOne = (PERIOD_W + 1)'(1);

  logic [PERIOD_W:0] r_cnt;
  logic [WidthW-1:0] r_width;
  logic              r_pulse;
  logic              r_step_edge;
  logic              w_fire;

  // Cancel only stops future rises; a pulse already high runs its full width.
  assign w_fire = !i_cancel && !i_load && (r_cnt == CntOne);

  // Interval counter, pulse-width counter and rising-edge strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_width     <= '0;
      r_pulse     <= 1'b0;
      r_step_edge <= 1'b0;
    end else begin
      r_step_edge <= w_fire;
      if (i_cancel) begin
        r_cnt <= '0;
      end else if (i_load) begin
        r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CntOne;
      end
      if (w_fire) begin
        r_pulse <= 1'b1;
        r_width <= WidthW'(PULSE_W);
      end else if (r_pulse) begin
        if (r_width == WidthW'(1)) r_pulse <= 1'b0;
        r_width <= r_width - WidthW'(1);
      end
    end
  end

  assign o_step_edge    = r_step_edge;
  assign o_rotate_pulse = r_pulse;
  assign o_pulse_fall   = r_pulse && (r_width == WidthW'(1));

endmodule

// File: rtl/stepper_ramp_gen.sv
// Linear-period ramp generator feeding the stepper phase driver.
// Accepts relative moves, paces step pulses through step_timer and tracks
// the absolute position.
module stepper_ramp_gen
  import motor_pkg::*;
#(
  parameter int unsigned PULSE_W     = 4,
  parameter int unsigned DIR_SETUP   = 8,
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [15:0]             cmd_steps,
  input  logic                    cmd_dir,
  input  logic [PERIOD_W-1:0]     start_period,
  input  logic [PERIOD_W-1:0]     min_period,
  input  logic [PERIOD_W-1:0]     accel,
  input  logic [LEVEL_W-1:0]      run_level,
  input  logic [LEVEL_W-1:0]      hold_level,
  input  logic                    drv_enable,
  input  logic                    abort,
  output logic                    rotate_pulse,
  output logic                    direction,
  output logic                    module_enable,
  output logic [LEVEL_W-1:0]      vref_level,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position
);

  localparam int unsigned HoldEff = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
  localparam int unsigned HoldW   = $clog2(HoldEff + 1);
  localparam logic [PERIOD_W:0] MinIntv   = (PERIOD_W + 1)'(2 * PULSE_W);
  localparam logic [PERIOD_W:0] SetupLoad = (PERIOD_W + 1)'(DIR_SETUP);

  ramp_state_t r_state, w_state_next;

  logic [15:0]             r_rem, r_ramp;
  logic [PERIOD_W-1:0]     r_period, r_start, r_min, r_accel;
  logic                    r_fin, r_dir, r_ready, r_busy, r_done, r_menable;
  logic [LEVEL_W-1:0]      r_vref;
  logic signed [POS_W-1:0] r_pos;
  logic [HoldW-1:0]        r_hold;

  logic                w_accept, w_abort_now, w_last, w_fin, w_done;
  logic                w_step_edge, w_pulse, w_pulse_fall, w_timer_load;
  logic [15:0]         w_rem_new, w_ramp_next;
  logic [PERIOD_W-1:0] w_period_next, w_diff;
  logic [PERIOD_W:0]   w_sum, w_eff, w_load_val;

  assign w_accept    = cmd_valid && (r_state == StIdle);
  assign w_abort_now = abort && (r_state == StRun);
  assign w_rem_new   = r_rem - 16'd1;
  assign w_last      = w_step_edge && (w_rem_new == '0);
  assign w_fin       = r_fin || w_last || w_abort_now;

  // Ramp law evaluated at each step edge: decel, accel or cruise.
  always_comb begin
    w_period_next = r_period;
    w_ramp_next   = r_ramp;
    w_sum         = {1'b0, r_period} + {1'b0, r_accel};
    w_diff        = (r_accel > r_period) ? '0 : r_period - r_accel;
    if ((w_rem_new != '0) && (w_rem_new <= r_ramp)) begin
      w_period_next = sat_period(w_sum);
      if (w_period_next > r_start) w_period_next = r_start;
      w_ramp_next = r_ramp - 16'd1;
    end else if (r_period > r_min) begin
      w_period_next = (w_diff < r_min) ? r_min : w_diff;
      w_ramp_next   = r_ramp + 16'd1;
    end
  end

  // Intervals shorter than two pulse widths would truncate the pulse.
  assign w_eff        = ({1'b0, w_period_next} < MinIntv) ? MinIntv : {1'b0, w_period_next};
  // The timer is reloaded one clock after the rise, hence the minus one.
  assign w_load_val   = (r_state == StIdle) ? SetupLoad : w_eff - (PERIOD_W + 1)'(1);
  assign w_timer_load = (w_accept && (cmd_steps != '0)) || (w_step_edge && !w_fin);

  step_timer #(
    .PULSE_W(PULSE_W)
  ) u_step_timer (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_timer_load),
    .i_load_val    (w_load_val),
    .i_cancel      (w_abort_now),
    .o_step_edge   (w_step_edge),
    .o_rotate_pulse(w_pulse),
    .o_pulse_fall  (w_pulse_fall)
  );

  // Next-state decode; RUN waits for the final pulse to fall before HOLD.
  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = StSetup;
      end
      StSetup: begin
        if (r_rem == '0) begin
          if (r_hold <= HoldW'(1)) begin
            w_state_next = StIdle;
            w_done       = 1'b1;
          end else begin
            w_state_next = StHold;
          end
        end else if (w_step_edge) begin
          w_state_next = (w_last && w_pulse_fall) ? StHold : StRun;
        end
      end
      StRun: begin
        if (w_fin && (w_pulse_fall || !w_pulse)) w_state_next = StHold;
      end
      StHold: begin
        if (r_hold <= HoldW'(1)) begin
          w_state_next = StIdle;
          w_done       = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State, move parameters, ramp registers and position.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_rem    <= '0;
      r_ramp   <= '0;
      r_period <= '0;
      r_start  <= '0;
      r_min    <= '0;
      r_accel  <= '0;
      r_fin    <= 1'b0;
      r_dir    <= 1'b0;
      r_pos    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_dir    <= cmd_dir;
        r_rem    <= cmd_steps;
        r_ramp   <= '0;
        r_period <= start_period;
        r_start  <= start_period;
        r_min    <= (min_period > start_period) ? start_period : min_period;
        r_accel  <= accel;
        r_fin    <= 1'b0;
      end else begin
        if (w_step_edge) begin
          r_rem    <= w_rem_new;
          r_period <= w_period_next;
          r_ramp   <= w_ramp_next;
          r_pos    <= r_dir ? r_pos + 1 : r_pos - 1;
        end
        if (w_last || w_abort_now) r_fin <= 1'b1;
      end
    end
  end

  // Hold timer restarts at every pulse fall, or at accept for an empty move.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else if ((w_accept && (cmd_steps == '0)) || w_pulse_fall) begin
      r_hold <= HoldW'(HoldEff);
    end else if (r_hold != '0) begin
      r_hold <= r_hold - HoldW'(1);
    end
  end

  // Registered status and driver-control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_menable <= 1'b0;
      r_vref    <= '0;
    end else begin
      r_ready   <= (w_state_next == StIdle);
      r_busy    <= (w_state_next != StIdle);
      r_done    <= w_done;
      r_menable <= (w_state_next != StIdle) || drv_enable;
      if (w_accept) begin
        r_vref <= run_level;
      end else if (w_done) begin
        r_vref <= hold_level;
      end
    end
  end

  assign cmd_ready     = r_ready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign module_enable = r_menable;
  assign vref_level    = r_vref;
  assign direction     = r_dir;
  assign position      = r_pos;
  assign rotate_pulse  = w_pulse;

endmodule

// File: tb/tb_stepper_ramp_gen.sv
// Scoreboard bench for stepper_ramp_gen: expected pulse rises and done events
// are queued when a move is issued; a negedge monitor compares them.
module tb_stepper_ramp_gen;

  localparam int PW = 4;
  localparam int DS = 8;
  localparam int HC = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_dir;
  logic [15:0] cmd_steps, start_period, min_period, accel;
  logic [3:0]  run_level, hold_level, vref_level;
  logic        drv_enable, abort;
  logic        rotate_pulse, direction, module_enable, busy, done;
  logic signed [31:0] position;

  stepper_ramp_gen #(
    .PULSE_W    (PW),
    .DIR_SETUP  (DS),
    .HOLD_CYCLES(HC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_steps    (cmd_steps),
    .cmd_dir      (cmd_dir),
    .start_period (start_period),
    .min_period   (min_period),
    .accel        (accel),
    .run_level    (run_level),
    .hold_level   (hold_level),
    .drv_enable   (drv_enable),
    .abort        (abort),
    .rotate_pulse (rotate_pulse),
    .direction    (direction),
    .module_enable(module_enable),
    .vref_level   (vref_level),
    .busy         (busy),
    .done         (done),
    .position     (position)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; bit dir;} rise_t;
  typedef struct {int cyc; int pos; int lvl;} done_t;

  rise_t exp_rise[$];
  done_t exp_done[$];
  int    model_pos = 0;
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 0;
  int    last_accept = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference profile: walk the step rules with plain integers.
  task automatic plan(input int a, input int steps, input int sp, input int mp, input int ac,
                      input bit dir, input int keep, input int hl, output int done_at);
    int cruise, p, ramp, rem, t, last, n;
    cruise = (mp > sp) ? sp : mp;
    p = sp; ramp = 0; rem = steps; t = a + DS; n = 0; last = 0;
    for (int i = 0; i < steps && i < keep; i++) begin
      exp_rise.push_back('{cyc: t, dir: dir});
      last = t;
      n++;
      rem--;
      if (rem == 0) break;
      if (rem <= ramp) begin
        p = (p + ac > sp) ? sp : p + ac;
        ramp--;
      end else if (p > cruise) begin
        p = (p - ac < cruise) ? cruise : p - ac;
        ramp++;
      end
      t += (p > 2 * PW) ? p : 2 * PW;
    end
    model_pos += dir ? n : -n;
    done_at = (n == 0) ? a + HC : last + PW + HC;
    exp_done.push_back('{cyc: done_at, pos: model_pos, lvl: hl});
  endtask

  task automatic issue(input int steps, input int sp, input int mp, input int ac, input bit dir,
                       input int rl, input int hl, input int keep, input bit hold_valid,
                       output int done_at);
    int budget;
    cmd_steps = 16'(steps); start_period = 16'(sp); min_period = 16'(mp); accel = 16'(ac);
    cmd_dir = dir; run_level = 4'(rl); hold_level = 4'(hl);
    cmd_valid = 1'b1;
    budget = 0;
    while (!cmd_ready && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) check("accept_timeout", 32'(budget), 32'(0));
    last_accept = cyc + 1;
    plan(last_accept, steps, sp, mp, ac, dir, keep, hl, done_at);
    @(negedge clk);
    if (!hold_valid) cmd_valid = 1'b0;
    check("ready_after_accept", cmd_ready, 0);
    check("busy_after_accept", busy, 1);
    check("dir_after_accept", direction, dir);
    check("vref_run", vref_level, rl);
    check("enable_moving", module_enable, 1);
  endtask

  task automatic wait_done(input int done_at);
    while (cyc < done_at + 2) @(negedge clk);
    check("done_seen", exp_done.size(), 0);
  endtask

  task automatic wait_rises(input int want, output int got);
    int budget;
    logic prev;
    got = 0; budget = 0; prev = rotate_pulse;
    while (got < want && budget < 5000) begin
      @(negedge clk);
      budget++;
      if (rotate_pulse && !prev) got++;
      prev = rotate_pulse;
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows a rise or a done.
  logic  prev_pulse = 1'b0;
  int    rise_at = 0;
  always @(negedge clk) begin
    rise_t r;
    done_t d;
    if (rst || !mon_en) begin
      prev_pulse = 1'b0;
    end else begin
      if (rotate_pulse && !prev_pulse) begin
        rise_at = cyc;
        if (exp_rise.size() == 0) begin
          check("rise_unexpected", 32'(cyc), 32'(-1));
        end else begin
          r = exp_rise.pop_front();
          check("rise_time", 32'(cyc), 32'(r.cyc));
          check("rise_dir", direction, r.dir);
        end
      end
      if (!rotate_pulse && prev_pulse) check("pulse_width", 32'(cyc - rise_at), 32'(PW));
      if (done) begin
        if (exp_done.size() == 0) begin
          check("done_unexpected", 32'(cyc), 32'(-1));
        end else begin
          d = exp_done.pop_front();
          check("done_time", 32'(cyc), 32'(d.cyc));
          check("done_position", position, 32'(d.pos));
          check("done_vref_hold", vref_level, 32'(d.lvl));
          check("done_ready", cmd_ready, 1);
          check("done_busy", busy, 0);
        end
      end
      prev_pulse = rotate_pulse;
    end
  end

  initial begin
    int d1, d2, got;
    rst = 1'b1; cmd_valid = 1'b0; cmd_steps = '0; cmd_dir = 1'b0;
    start_period = '0; min_period = '0; accel = '0;
    run_level = '0; hold_level = '0; drv_enable = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pulse", rotate_pulse, 0);
    check("rst_dir", direction, 0);
    check("rst_enable", module_enable, 0);
    check("rst_vref", vref_level, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_position", position, 0);
    check("rst_ready", cmd_ready, 1);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Idle enable follows drv_enable.
    drv_enable = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_enable_on", module_enable, 1);
    drv_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_enable_off", module_enable, 0);

    // Basic ramp, triangular, reverse.
    issue(10, 100, 40, 20, 1'b1, 12, 3, 1000, 1'b0, d1);
    wait_done(d1);
    issue(3, 100, 40, 20, 1'b1, 12, 3, 1000, 1'b0, d1);
    wait_done(d1);
    issue(5, 100, 40, 20, 1'b0, 10, 2, 1000, 1'b0, d1);
    wait_done(d1);

    // Zero steps; abort during HOLD must not matter.
    issue(0, 100, 40, 20, 1'b1, 9, 3, 1000, 1'b0, d1);
    repeat (HC / 2) @(negedge clk);
    check("zero_vref_run", vref_level, 9);
    check("zero_busy", busy, 1);
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    wait_done(d1);

    // Abort two clocks after pulse 5 rises.
    issue(100, 100, 40, 20, 1'b1, 11, 4, 5, 1'b0, d1);
    wait_rises(5, got);
    check("abort_rise5_seen", 32'(got), 32'(5));
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 0;
    wait_done(d1);

    // cmd_valid held through a move: next accept only once idle again.
    issue(6, 60, 30, 10, 1'b1, 7, 1, 1000, 1'b1, d1);
    issue(6, 60, 30, 10, 1'b1, 7, 1, 1000, 1'b0, d2);
    check("held_accept", 32'(last_accept), 32'(d1 + 1));
    wait_done(d2);

    // Randomized moves, including min_period above start_period.
    for (int k = 0; k < 10; k++) begin
      issue(int'($urandom_range(0, 20)), int'($urandom_range(20, 120)),
            int'($urandom_range(5, 140)), int'($urandom_range(0, 40)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), 1000, 1'b0, d1);
      wait_done(d1);
    end

    // Reset mid-pulse.
    issue(10, 100, 40, 20, 1'b1, 12, 3, 1000, 1'b0, d1);
    wait_rises(1, got);
    check("rst_test_rise_seen", 32'(got), 32'(1));
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pulse", rotate_pulse, 0);
    check("midrst_position", position, 0);
    check("midrst_ready", cmd_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_vref", vref_level, 0);
    rst = 1'b0;
    exp_rise.delete();
    exp_done.delete();
    model_pos = 0;
    @(negedge clk);
    mon_en = 1'b1;
    issue(3, 50, 30, 10, 1'b0, 5, 2, 1000, 1'b0, d1);
    wait_done(d1);

    check("rise_leftover", exp_rise.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stepper_ramp_gen.md
# stepper_ramp_gen

Motion-profile stage that sits directly upstream of the stepper phase driver. It accepts a relative move command (step count plus direction) over a valid/ready handshake and generates the driver's `rotate_pulse`, `direction`, `module_enable` and `vref_level` inputs. Step rate follows a symmetric linear-period ramp: accelerate, cruise, decelerate. It also maintains a signed absolute position count.

## Interface
- `PULSE_W`, default 4: `rotate_pulse` high time in clocks, ≥1.
- `DIR_SETUP`, default 8: clocks from command accept to first pulse rising edge, ≥2.
- `HOLD_CYCLES`, default 1000: clocks at run current after the last pulse falls.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous reset, active-high.
- `cmd_valid` in 1: move command valid.
- `cmd_ready` out 1: high in IDLE only.
- `cmd_steps` in 16: step count, unsigned; 0 is legal.
- `cmd_dir` in 1: 1 = forward (driver counts up).
- `start_period` in 16: initial and final step interval in clocks; sampled on accept.
- `min_period` in 16: cruise interval; sampled on accept.
- `accel` in 16: period change per step; sampled on accept.
- `run_level` in 4: current level while moving.
- `hold_level` in 4: current level at rest.
- `drv_enable` in 1: keep driver enabled while idle.
- `abort` in 1: stop after the current pulse.
- `rotate_pulse` out 1: step pulse to the driver.
- `direction` out 1: direction to the driver.
- `module_enable` out 1: driver standby control.
- `vref_level` out 4: driver current setting.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-clock pulse on return to IDLE.
- `position` out 32: signed absolute step count.

## Operation
- States: IDLE, SETUP, RUN, HOLD. The ramp phase (accel, cruise or decel) is derived inside RUN.
- IDLE → SETUP on `cmd_valid && cmd_ready`. On accept:
  - latch `cmd_dir` into `direction`;
  - load remaining = `cmd_steps`, p = `start_period`, ramp = 0;
  - set `vref_level` = `run_level`.
- SETUP:
  - `cmd_steps` = 0: go to HOLD with no pulse.
  - Otherwise, first pulse rises exactly `DIR_SETUP` clocks after the accept cycle.
- On each pulse rising edge, update in this order:
  - remaining -= 1; `position` += 1 if `direction`, else -= 1;
  - if remaining = 0: finish;
  - else if remaining ≤ ramp: p = min(p + `accel`, `start_period`), ramp -= 1 (decel);
  - else if p > `min_period`: p = max(p − `accel`, `min_period`), ramp += 1 (accel);
  - else: p unchanged (cruise).
  - The next rising edge follows p clocks later.
- Pulse high time:
  - Pulse stays high `PULSE_W` clocks and is never truncated, including on `abort`.
  - The effective interval is max(p, 2·`PULSE_W`).
- Arithmetic width rules:
  - All period arithmetic is 17-bit internally and saturates to [0, 0xFFFF].
  - If `min_period` > `start_period`, `start_period` is used as the cruise period (constant rate).
- `abort` in RUN: finish with the pulse in progress (or immediately if between pulses), then go to HOLD. `position` stays exact.
- HOLD:
  - Runs `HOLD_CYCLES` clocks counted from the last pulse falling edge (from SETUP entry if `cmd_steps` = 0).
  - Then `vref_level` = `hold_level`, `done` = 1 for one clock, state → IDLE.
- `module_enable` = `busy` || `drv_enable`, registered.
- `direction` changes only on command accept.

## Timing
- Reset values: `rotate_pulse` 0, `direction` 0, `module_enable` 0, `vref_level` 0, `busy` 0, `done` 0, `position` 0, `cmd_ready` 1 (IDLE).
- Reset mid-move: all outputs reach reset values on the next edge; an in-flight pulse drops immediately.
- Latency and registering:
  - All outputs are registered.
  - `cmd_ready` falls the clock after accept.
  - `busy` rises the clock after accept.
- `cmd_valid` while `cmd_ready` = 0 is ignored; no queuing.
- `abort` in IDLE or HOLD has no effect.

## Structure
- Shared package `motor_pkg`: state enum `ramp_state_t`, `POS_W` = 32, `PERIOD_W` = 16, `LEVEL_W` = 4.
- One sub-module, `step_timer`: loadable period down-counter plus pulse-width counter. It outputs `step_edge`, a one-clock strobe at the pulse rising edge, and drives `rotate_pulse`.
- The ramp arithmetic, step counting and FSM stay in the top module.

## Test plan
- Basic ramp: steps = 10, start = 100, min = 40, accel = 20, `PULSE_W` = 4, `DIR_SETUP` = 8 → first rise 8 clocks after accept; rise-to-rise intervals 80, 60, 40, 40, 40, 40, 60, 80, 100; `position` = 10; `done` one clock after `HOLD_CYCLES`.
- Triangular move: steps = 3, same profile → intervals 80, 100; `position` = 3.
- Reverse move: `cmd_dir` = 0, steps = 5 from `position` = 10 → `position` = 5; `direction` stable low from the clock after accept through the last pulse.
- Zero steps: steps = 0 → no pulse; `vref_level` = `run_level` for `HOLD_CYCLES`, then `hold_level`; `done` pulses.
- Abort: steps = 100, `abort` asserted 2 clocks after pulse 5 rises → pulse 5 is full width, no pulse 6, `position` = 5, HOLD then `done`.
- Reset and handshake:
  - `rst` mid-pulse → `rotate_pulse` = 0, `position` = 0, `cmd_ready` = 1 the next clock.
  - `cmd_valid` held during a move → not accepted until IDLE.
